// File: rtl/ysyx_25050136_lsu.sv
// Memory stage: accepts the EX bundle, runs loads/stores on a req/ack bus,
// aligns store data and extracts/extends load data, hands results to WB and
// drives the bypass network.
// Optional feature: define LSU_MISALIGN_CHECK_EN to fault misaligned half/word
// accesses locally instead of issuing them.
module ysyx_25050136_lsu #(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic                  in_ebreak_i,
   input  logic [ADDR_WIDTH-1:0] in_rd_i,
   input  logic                  in_rd_en_i,
   input  logic [31:0]           in_gpr_wdata_i,
   input  logic                  in_lsu_ren_i,
   input  logic                  in_lsu_wen_i,
   input  logic [3:0]            in_lsu_mask_i,
   input  logic                  in_lsu_signed_i,
   input  logic [31:0]           in_lsu_addr_i,
   input  logic [31:0]           in_lsu_wdata_i,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [31:0]           mem_addr_o,
   output logic [3:0]            mem_wstrb_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_ack_i,
   input  logic [31:0]           mem_rdata_i,
   input  logic                  mem_err_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  out_ebreak_o,
   output logic [ADDR_WIDTH-1:0] out_rd_o,
   output logic                  out_rd_en_o,
   output logic [31:0]           out_wdata_o,
   output logic                  out_err_o,
   output logic                  wen_o,
   output logic                  wvalid_o,
   output logic [ADDR_WIDTH-1:0] waddr_o,
   output logic [31:0]           wdata_o
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t state_q, state_d;

   logic                  ebreak_q, rd_en_q, err_q, load_q, signed_q, we_q;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic [31:0]           addr_q, wdata_q, mem_wdata_q;
   logic [3:0]            mask_q, wstrb_q;

   logic        in_fire_c, is_mem_c, misalign_c;
   state_t      accept_state_c;
   logic [31:0] shifted_c, load_data_c;

   assign in_ready_o = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
   assign in_fire_c  = in_valid_i & in_ready_o;
   assign is_mem_c   = in_lsu_ren_i | in_lsu_wen_i;

`ifdef LSU_MISALIGN_CHECK_EN
   assign misalign_c = is_mem_c &
                       (((in_lsu_mask_i == 4'b0011) & in_lsu_addr_i[0]) |
                        ((in_lsu_mask_i == 4'b1111) & (in_lsu_addr_i[1:0] != 2'b00)));
`else
   assign misalign_c = 1'b0;
`endif

   // Destination state for a newly accepted instruction
   always_comb begin
      accept_state_c = DONE;
      if (!misalign_c && is_mem_c) accept_state_c = REQ;
   end

   // Shift the read word down to the accessed byte, then mask and extend
   always_comb begin
      shifted_c   = mem_rdata_i >> {addr_q[1:0], 3'b000};
      load_data_c = shifted_c;
      case (mask_q)
         4'b0001: load_data_c = {{24{signed_q & shifted_c[7]}}, shifted_c[7:0]};
         4'b0011: load_data_c = {{16{signed_q & shifted_c[15]}}, shifted_c[15:0]};
         default: load_data_c = shifted_c;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_fire_c) state_d = accept_state_c;
         REQ:  if (mem_ack_i) state_d = DONE;
         DONE: begin
            if (in_fire_c)        state_d = accept_state_c;
            else if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Instruction capture on accept, result/error capture on bus ack
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ebreak_q    <= 1'b0;
         rd_q        <= '0;
         rd_en_q     <= 1'b0;
         err_q       <= 1'b0;
         load_q      <= 1'b0;
         signed_q    <= 1'b0;
         we_q        <= 1'b0;
         mask_q      <= 4'b0;
         wstrb_q     <= 4'b0;
         addr_q      <= 32'b0;
         wdata_q     <= 32'b0;
         mem_wdata_q <= 32'b0;
      end else if (in_fire_c) begin
         ebreak_q    <= in_ebreak_i;
         rd_q        <= in_rd_i;
         // Pure stores never write rd; ren&wen counts as a load
         rd_en_q     <= in_rd_en_i & (in_lsu_ren_i | ~in_lsu_wen_i) & ~misalign_c;
         err_q       <= misalign_c;
         load_q      <= in_lsu_ren_i;
         signed_q    <= in_lsu_signed_i;
         we_q        <= in_lsu_wen_i & ~in_lsu_ren_i;
         mask_q      <= in_lsu_mask_i;
         wstrb_q     <= 4'(in_lsu_mask_i << in_lsu_addr_i[1:0]);
         addr_q      <= in_lsu_addr_i;
         wdata_q     <= in_gpr_wdata_i;
         mem_wdata_q <= in_lsu_wdata_i << {in_lsu_addr_i[1:0], 3'b000};
      end else if ((state_q == REQ) && mem_ack_i) begin
         err_q <= mem_err_i;
         if (mem_err_i) rd_en_q <= 1'b0;
         if (load_q)    wdata_q <= load_data_c;
      end
   end

   assign mem_req_o    = (state_q == REQ);
   assign mem_we_o     = we_q;
   assign mem_addr_o   = addr_q;
   assign mem_wstrb_o  = wstrb_q;
   assign mem_wdata_o  = mem_wdata_q;

   assign out_valid_o  = (state_q == DONE);
   assign out_ebreak_o = ebreak_q;
   assign out_rd_o     = rd_q;
   assign out_rd_en_o  = rd_en_q;
   assign out_wdata_o  = wdata_q;
   assign out_err_o    = err_q;

   assign wen_o        = rd_en_q & (state_q != IDLE);
   assign wvalid_o     = wen_o & (state_q == DONE);
   assign waddr_o      = rd_q;
   assign wdata_o      = wdata_q;

endmodule

// File: tb/tb_ysyx_25050136_lsu.sv
// Scoreboard bench for the memory stage: stimulus pushes expected WB bundles,
// a negedge monitor pops and compares on every WB handshake.
module tb_ysyx_25050136_lsu;

   localparam int unsigned AW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid_i, in_ready_o, in_ebreak_i, in_rd_en_i;
   logic [AW-1:0] in_rd_i;
   logic [31:0]   in_gpr_wdata_i, in_lsu_addr_i, in_lsu_wdata_i;
   logic          in_lsu_ren_i, in_lsu_wen_i, in_lsu_signed_i;
   logic [3:0]    in_lsu_mask_i;
   logic          mem_req_o, mem_we_o, mem_ack_i, mem_err_i;
   logic [31:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]    mem_wstrb_o;
   logic          out_valid_o, out_ready_i, out_ebreak_o, out_rd_en_o, out_err_o;
   logic [AW-1:0] out_rd_o, waddr_o;
   logic [31:0]   out_wdata_o, wdata_o;
   logic          wen_o, wvalid_o;

   ysyx_25050136_lsu #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_ebreak_i(in_ebreak_i),
      .in_rd_i(in_rd_i), .in_rd_en_i(in_rd_en_i), .in_gpr_wdata_i(in_gpr_wdata_i),
      .in_lsu_ren_i(in_lsu_ren_i), .in_lsu_wen_i(in_lsu_wen_i), .in_lsu_mask_i(in_lsu_mask_i),
      .in_lsu_signed_i(in_lsu_signed_i), .in_lsu_addr_i(in_lsu_addr_i),
      .in_lsu_wdata_i(in_lsu_wdata_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_ebreak_o(out_ebreak_o),
      .out_rd_o(out_rd_o), .out_rd_en_o(out_rd_en_o), .out_wdata_o(out_wdata_o),
      .out_err_o(out_err_o),
      .wen_o(wen_o), .wvalid_o(wvalid_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          ebreak;
      logic [AW-1:0] rd;
      logic          rd_en;
      logic          err;
      logic [31:0]   wdata;
   } wb_t;

   wb_t sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  n_push  = 0;
   int  n_pop   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] wdata, input logic [AW-1:0] rd,
                       input logic rd_en, input logic err, input logic ebreak);
      wb_t e;
      e.ebreak = ebreak; e.rd = rd; e.rd_en = rd_en; e.err = err; e.wdata = wdata;
      sb.push_back(e);
      n_push++;
   endtask

   // Monitor: compare every WB handshake against the head of the scoreboard
   always @(negedge clk) begin
      if (reset_n && out_valid_o && out_ready_i) begin
         if (sb.size() == 0) begin
            check("wb_unexpected", 64'(out_wdata_o), 64'hDEAD_0000);
         end else begin
            wb_t e;
            wb_t a;
            e = sb.pop_front();
            n_pop++;
            a.ebreak = out_ebreak_o; a.rd = out_rd_o; a.rd_en = out_rd_en_o;
            a.err = out_err_o; a.wdata = out_wdata_o;
            check("wb_bundle", 64'(a), 64'(e));
         end
      end
   end

   // Present one instruction and hold it until accepted; returns stall cycles
   task automatic issue(input logic ren, input logic wen, input logic [3:0] mask,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] gpr, input logic [AW-1:0] rd,
                        input logic rd_en, input logic ebreak, output int waits);
      in_valid_i = 1'b1; in_lsu_ren_i = ren; in_lsu_wen_i = wen; in_lsu_mask_i = mask;
      in_lsu_signed_i = sgn; in_lsu_addr_i = addr; in_lsu_wdata_i = wdata;
      in_gpr_wdata_i = gpr; in_rd_i = rd; in_rd_en_i = rd_en; in_ebreak_i = ebreak;
      #1;
      waits = 0;
      while (!in_ready_o && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready_o) check("issue_timeout", 64'(in_ready_o), 64'd1);
      @(posedge clk); #1;
      in_valid_i = 1'b0;
   endtask

   // Wait for a bus request (bounded) and complete it with one ack cycle
   task automatic do_ack(input logic [31:0] rdata, input logic err);
      int n = 0;
      while (!mem_req_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!mem_req_o) check("ack_timeout", 64'(mem_req_o), 64'd1);
      mem_ack_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
      @(posedge clk); #1;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int w;
      reset_n = 1'b0; in_valid_i = 1'b0; in_ebreak_i = 1'b0; in_rd_i = '0; in_rd_en_i = 1'b0;
      in_gpr_wdata_i = 32'h0; in_lsu_ren_i = 1'b0; in_lsu_wen_i = 1'b0; in_lsu_mask_i = 4'h0;
      in_lsu_signed_i = 1'b0; in_lsu_addr_i = 32'h0; in_lsu_wdata_i = 32'h0;
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0; out_ready_i = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_mem_req",   64'(mem_req_o),   64'd0);
      check("rst_in_ready",  64'(in_ready_o),  64'd1);
      check("rst_wdata",     64'(out_wdata_o), 64'd0);
      check("rst_bypass",    64'({wen_o, wvalid_o}), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // ALU op: one-cycle latency, bypass valid
      push(32'h1234_5678, 4'd5, 1'b1, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 4'd5, 1'b1, 1'b0, w);
      @(negedge clk);
      check("alu_out_valid", 64'(out_valid_o), 64'd1);
      check("alu_bypass", 64'({wen_o, wvalid_o, waddr_o, wdata_o}),
            64'({1'b1, 1'b1, 4'd5, 32'h1234_5678}));
      drain();

      // lb signed at byte 3
      push(32'hFFFF_FF80, 4'd7, 1'b1, 1'b0, 1'b1);
      issue(1'b1, 1'b0, 4'b0001, 1'b1, 32'h8000_0003, 32'h0, 32'h0, 4'd7, 1'b1, 1'b1, w);
      @(negedge clk);
      check("lb_req", 64'({mem_req_o, mem_we_o, mem_addr_o}), 64'({1'b1, 1'b0, 32'h8000_0003}));
      check("lb_bypass_pending", 64'({wen_o, wvalid_o}), 64'({1'b1, 1'b0}));
      @(negedge clk);
      check("lb_req_stable", 64'({mem_req_o, mem_addr_o}), 64'({1'b1, 32'h8000_0003}));
      @(posedge clk); #1;
      do_ack(32'h80AA_BBCC, 1'b0);
      drain();

      // sh at halfword 1
      push(32'h0000_0011, 4'd3, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 4'b0011, 1'b0, 32'h8000_0002, 32'h0000_BEEF, 32'h0000_0011, 4'd3, 1'b1, 1'b0, w);
      @(negedge clk);
      check("sh_bus", 64'({mem_we_o, mem_wstrb_o, mem_wdata_o}), 64'({1'b1, 4'b1100, 32'hBEEF_0000}));
      check("sh_no_bypass", 64'(wen_o), 64'd0);
      @(posedge clk); #1;
      do_ack(32'hFFFF_FFFF, 1'b0);
      drain();

      // lhu / lh at halfword 1, lbu at byte 1
      push(32'h0000_F00D, 4'd1, 1'b1, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 4'b0011, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 4'd1, 1'b1, 1'b0, w);
      do_ack(32'hF00D_1234, 1'b0);
      drain();
      push(32'hFFFF_F00D, 4'd2, 1'b1, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 4'b0011, 1'b1, 32'h0000_0102, 32'h0, 32'h0, 4'd2, 1'b1, 1'b0, w);
      do_ack(32'hF00D_1234, 1'b0);
      drain();
      push(32'h0000_0080, 4'd4, 1'b1, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 4'b0001, 1'b0, 32'h0000_0201, 32'h0, 32'h0, 4'd4, 1'b1, 1'b0, w);
      do_ack(32'h1234_80FF, 1'b0);
      drain();

      // ren & wen both set behaves as load with no write
      push(32'hCAFE_BABE, 4'd6, 1'b1, 1'b0, 1'b0);
      issue(1'b1, 1'b1, 4'b1111, 1'b0, 32'h0000_0010, 32'h5555_5555, 32'h0, 4'd6, 1'b1, 1'b0, w);
      @(negedge clk);
      check("rw_as_load_we", 64'({mem_req_o, mem_we_o}), 64'({1'b1, 1'b0}));
      @(posedge clk); #1;
      do_ack(32'hCAFE_BABE, 1'b0);
      drain();

      // Bus error: err set, rd write suppressed
      push(32'h0BAD_0BAD, 4'd8, 1'b0, 1'b1, 1'b0);
      issue(1'b1, 1'b0, 4'b1111, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 4'd8, 1'b1, 1'b0, w);
      do_ack(32'h0BAD_0BAD, 1'b1);
      drain();

      // Stray ack while idle is ignored
      mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_1111;
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      @(negedge clk);
      check("stray_ack", 64'({out_valid_o, mem_req_o}), 64'd0);
      @(posedge clk); #1;

      // WB backpressure then back-to-back accept
      out_ready_i = 1'b0;
      push(32'hAAAA_0001, 4'd9, 1'b1, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 32'hAAAA_0001, 4'd9, 1'b1, 1'b0, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_hold", 64'({out_valid_o, in_ready_o, out_wdata_o}),
               64'({1'b1, 1'b0, 32'hAAAA_0001}));
      end
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      push(32'hBBBB_0002, 4'd10, 1'b1, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 32'hBBBB_0002, 4'd10, 1'b1, 1'b0, w);
      check("b2b_accept_waits", 64'(w), 64'd0);
      drain();

      // Misaligned word access
`ifdef LSU_MISALIGN_CHECK_EN
      push(32'h0000_0042, 4'd11, 1'b0, 1'b1, 1'b0);
      issue(1'b1, 1'b0, 4'b1111, 1'b0, 32'h8000_0002, 32'h0, 32'h0000_0042, 4'd11, 1'b1, 1'b0, w);
      @(negedge clk);
      check("misalign_no_req", 64'({mem_req_o, out_valid_o}), 64'({1'b0, 1'b1}));
      drain();
`else
      push(32'h0000_0042, 4'd11, 1'b0, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 4'b1111, 1'b0, 32'h8000_0003, 32'hAABB_CCDD, 32'h0000_0042, 4'd11, 1'b1, 1'b0, w);
      @(negedge clk);
      check("sw_trunc", 64'({mem_req_o, mem_wstrb_o, mem_wdata_o}), 64'({1'b1, 4'b1000, 32'hDD00_0000}));
      @(posedge clk); #1;
      do_ack(32'h0, 1'b0);
      drain();
`endif

      // Reset mid-request; a late ack afterwards is ignored
      issue(1'b1, 1'b0, 4'b1111, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 4'd12, 1'b1, 1'b0, w);
      @(negedge clk);
      check("pre_rst_req", 64'(mem_req_o), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_async", 64'({mem_req_o, out_valid_o}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
      @(negedge clk);
      check("late_ack_ignored", 64'({mem_req_o, out_valid_o, in_ready_o}), 64'({1'b0, 1'b0, 1'b1}));

      drain();
      check("sb_balance", 64'(n_pop), 64'(n_push));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
